// File: rtl/lsu_ahb_pkg.sv
// lsu_ahb_pkg: shared encodings for the AHB-Lite load/store unit.
// Size codes, HTRANS/HBURST/HPROT values, FSM states, data-phase bundle.
package lsu_ahb_pkg;

    localparam logic [1:0] LSU_SIZE_B = 2'b00;
    localparam logic [1:0] LSU_SIZE_H = 2'b01;
    localparam logic [1:0] LSU_SIZE_W = 2'b10;
    localparam logic [1:0] LSU_SIZE_D = 2'b11;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DATA    = 4'b0001;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_ERR1
    } lsu_state_e;

    typedef struct packed {
        logic       write;
        logic [1:0] size;
        logic       uns;
        logic       mis;
    } dp_t;

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] size_mask(input logic [1:0] size);
        size_mask = 3'b000;
        unique case (size)
            LSU_SIZE_B: size_mask = 3'b000;
            LSU_SIZE_H: size_mask = 3'b001;
            LSU_SIZE_W: size_mask = 3'b011;
            LSU_SIZE_D: size_mask = 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_ahb_if.sv
// lsu_ahb_if: LSU request/response handshake plus AHB-Lite master bus.
// master = the LSU side, slave = the core/bus environment side.
interface lsu_ahb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);

    logic              lsu_req_valid;
    logic              lsu_req_ready;
    logic              lsu_req_write;
    logic [1:0]        lsu_req_size;
    logic              lsu_req_unsigned;
    logic [ADDR_W-1:0] lsu_req_addr;
    logic [DATA_W-1:0] lsu_req_wdata;
    logic              lsu_resp_valid;
    logic [DATA_W-1:0] lsu_resp_rdata;
    logic              lsu_resp_err;
    logic              lsu_misaligned;

    logic              dbus_hwrite;
    logic [2:0]        dbus_hsize;
    logic [2:0]        dbus_hburst;
    logic [3:0]        dbus_hport;
    logic [1:0]        dbus_htrans;
    logic              dbus_hmastlock;
    logic [ADDR_W-1:0] dbus_haddr;
    logic [DATA_W-1:0] dbus_hwdata;
    logic              dbus_hready;
    logic              dbus_hresp;
    logic [DATA_W-1:0] dbus_hrdata;

    modport master (
        input  lsu_req_valid, lsu_req_write, lsu_req_size,
        input  lsu_req_unsigned, lsu_req_addr, lsu_req_wdata,
        output lsu_req_ready, lsu_resp_valid, lsu_resp_rdata,
        output lsu_resp_err, lsu_misaligned,
        output dbus_hwrite, dbus_hsize, dbus_hburst, dbus_hport,
        output dbus_htrans, dbus_hmastlock, dbus_haddr, dbus_hwdata,
        input  dbus_hready, dbus_hresp, dbus_hrdata
    );

    modport slave (
        output lsu_req_valid, lsu_req_write, lsu_req_size,
        output lsu_req_unsigned, lsu_req_addr, lsu_req_wdata,
        input  lsu_req_ready, lsu_resp_valid, lsu_resp_rdata,
        input  lsu_resp_err, lsu_misaligned,
        input  dbus_hwrite, dbus_hsize, dbus_hburst, dbus_hport,
        input  dbus_htrans, dbus_hmastlock, dbus_haddr, dbus_hwdata,
        output dbus_hready, dbus_hresp, dbus_hrdata
    );

endinterface

// File: rtl/lsu_ahb_rdata_align.sv
// lsu_ahb_rdata_align: lane select and sign/zero extension of bus read data.
// Ports: rdata (bus word), off (byte lane), size, uns, data (extended result).
module lsu_ahb_rdata_align #(
    parameter int DATA_W = 32,
    parameter int OW     = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [OW-1:0]     off,
    input  logic [1:0]        size,
    input  logic              uns,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] lane;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] top;
    logic [6:0]        nbits;
    logic              sbit;

    // mask covers the access width; top isolates its sign bit.
    // A width >= DATA_W shifts everything out, giving a full mask.
    always_comb begin
        lane  = rdata >> {off, 3'b000};
        nbits = 7'd8 << size;
        mask  = ~({DATA_W{1'b1}} << nbits);
        top   = mask & ~(mask >> 1);
        sbit  = ~uns & (|(lane & top));
        data  = (lane & mask) | ({DATA_W{sbit}} & ~mask);
    end

endmodule

// File: rtl/lsu_ahb.sv
// lsu_ahb: pipelined AHB-Lite load/store unit (clk, rst_n, bus master modport).
// Macro LSU_MISALIGN_TRAP_EN: trap misaligned accesses instead of aligning down.
module lsu_ahb
    import lsu_ahb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input logic       clk,
    input logic       rst_n,
    lsu_ahb_if.master bus
);

    localparam int OW = $clog2(DATA_W / 8);

    lsu_state_e        state;
    lsu_state_e        state_nx;
    dp_t               dp;
    logic [OW-1:0]     dp_off;
    logic [DATA_W-1:0] hwdata_q;
    logic [DATA_W-1:0] wrep;
    logic [DATA_W-1:0] ext;
    logic [2:0]        smask;
    logic [ADDR_W-1:0] addr_al;
    logic              req_mis;
    logic              err1_now;
    logic              cancel;
    logic              accept;
    logic              resp_valid;
    logic              resp_err;

    assign smask   = size_mask(bus.lsu_req_size);
    assign addr_al = {bus.lsu_req_addr[ADDR_W-1:3],
                      bus.lsu_req_addr[2:0] & ~smask};

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_mis        = |(bus.lsu_req_addr[2:0] & smask);
    assign bus.dbus_haddr = bus.lsu_req_addr;
`else
    assign req_mis        = 1'b0;
    assign bus.dbus_haddr = addr_al;
`endif

    // First ERROR cycle must already suppress the next address phase.
    assign err1_now = (state == ST_DATA) & ~dp.mis
                    & bus.dbus_hresp & ~bus.dbus_hready;
    assign cancel   = (state == ST_ERR1) | err1_now;

    assign bus.lsu_req_ready = bus.dbus_hready & ~cancel;
    assign accept = bus.lsu_req_valid & bus.lsu_req_ready;

    // A trapped misaligned access has no bus transfer, so ignore hready.
    assign resp_valid = ((state == ST_DATA) & (dp.mis | bus.dbus_hready))
                      | ((state == ST_ERR1) & bus.dbus_hready);
    assign resp_err   = resp_valid & ~dp.mis & bus.dbus_hresp;

    assign bus.dbus_htrans =
        (bus.lsu_req_valid & ~cancel & ~req_mis) ? HTRANS_NONSEQ
                                                 : HTRANS_IDLE;
    assign bus.dbus_hwrite    = bus.lsu_req_write;
    assign bus.dbus_hsize     = {1'b0, bus.lsu_req_size};
    assign bus.dbus_hburst    = HBURST_SINGLE;
    assign bus.dbus_hport     = HPROT_DATA;
    assign bus.dbus_hmastlock = 1'b0;
    assign bus.dbus_hwdata    = hwdata_q;

    always_comb begin
        wrep = bus.lsu_req_wdata;
        unique case (bus.lsu_req_size)
            LSU_SIZE_B: wrep = {(DATA_W / 8){bus.lsu_req_wdata[7:0]}};
            LSU_SIZE_H: wrep = {(DATA_W / 16){bus.lsu_req_wdata[15:0]}};
            LSU_SIZE_W: wrep = {(DATA_W / 32){bus.lsu_req_wdata[31:0]}};
            LSU_SIZE_D: wrep = bus.lsu_req_wdata;
        endcase
    end

    always_comb begin
        state_nx = state;
        if (accept) begin
            state_nx = ST_DATA;
        end else if (err1_now) begin
            state_nx = ST_ERR1;
        end else if (resp_valid) begin
            state_nx = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            dp       <= '0;
            dp_off   <= '0;
            hwdata_q <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                dp.write <= bus.lsu_req_write;
                dp.size  <= bus.lsu_req_size;
                dp.uns   <= bus.lsu_req_unsigned;
                dp.mis   <= req_mis;
                dp_off   <= addr_al[OW-1:0];
                hwdata_q <= wrep;
            end
        end
    end

    lsu_ahb_rdata_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .rdata (bus.dbus_hrdata),
        .off   (dp_off),
        .size  (dp.size),
        .uns   (dp.uns),
        .data  (ext)
    );

    assign bus.lsu_resp_valid = resp_valid;
    assign bus.lsu_resp_err   = resp_err;
    assign bus.lsu_misaligned = resp_valid & dp.mis;
    assign bus.lsu_resp_rdata =
        (resp_valid & ~resp_err & ~dp.write & ~dp.mis) ? ext : '0;

endmodule

// File: tb/tb_lsu_ahb.sv
// tb_lsu_ahb: self-checking bench for lsu_ahb (32-bit and 64-bit instances).
// Vector table, directed error/misalign/reset sequences, random vs. model.
module tb_lsu_ahb;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_ahb_if #(.DATA_W(32), .ADDR_W(32)) bif ();
    lsu_ahb_if #(.DATA_W(64), .ADDR_W(32)) bif64 ();

    lsu_ahb #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    lsu_ahb #(.DATA_W(64), .ADDR_W(32)) dut64 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif64)
    );

    typedef struct {
        logic        v, w, u;
        logic [1:0]  sz;
        logic [31:0] a, wd;
        logic        hr, he;
        logic [31:0] hd;
        logic [1:0]  et;
        logic        er, ev, ee;
        logic [31:0] ed;
        logic        cw;
        logic [31:0] ewd;
    } vec_t;

    typedef struct {
        logic        w, u, mis;
        logic [1:0]  sz;
        logic [31:0] addr, wdata;
    } req_t;

    int npass = 0;
    int ntot  = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic drv(input logic v, w, u, input logic [1:0] sz,
                       input logic [31:0] a, wd, input logic hr, he,
                       input logic [31:0] hd);
        @(negedge clk);
        bif.lsu_req_valid    = v;
        bif.lsu_req_write    = w;
        bif.lsu_req_unsigned = u;
        bif.lsu_req_size     = sz;
        bif.lsu_req_addr     = a;
        bif.lsu_req_wdata    = wd;
        bif.dbus_hready      = hr;
        bif.dbus_hresp       = he;
        bif.dbus_hrdata      = hd;
        #1;
    endtask

    task automatic check_vec(input int i, input vec_t t);
        chk($sformatf("v%0d_htrans", i), bif.dbus_htrans, t.et);
        if (t.et == 2'b10) begin
            chk($sformatf("v%0d_haddr", i), bif.dbus_haddr, t.a);
            chk($sformatf("v%0d_hsize", i), bif.dbus_hsize, {1'b0, t.sz});
            chk($sformatf("v%0d_hwrite", i), bif.dbus_hwrite, t.w);
        end
        chk($sformatf("v%0d_ready", i), bif.lsu_req_ready, t.er);
        chk($sformatf("v%0d_rvalid", i), bif.lsu_resp_valid, t.ev);
        chk($sformatf("v%0d_err", i), bif.lsu_resp_err, t.ee);
        chk($sformatf("v%0d_rdata", i), bif.lsu_resp_rdata, t.ed);
        chk($sformatf("v%0d_mis", i), bif.lsu_misaligned, 1'b0);
        if (t.cw) chk($sformatf("v%0d_hwdata", i), bif.dbus_hwdata, t.ewd);
    endtask

    // Reference: pick the byte lane, then extend to the register width.
    function automatic logic [31:0] exp_load(input req_t r,
                                             input logic [31:0] d);
        int nb;
        int lane;
        longint unsigned v;
        longint unsigned m;
        if (r.w || r.mis) return 32'h0;
        nb   = 1 << r.sz;
        lane = int'(r.addr % 4) & ~(nb - 1);
        v    = {32'h0, d} >> (8 * lane);
        m    = (64'd1 << (8 * nb)) - 1;
        v    = v & m;
        if (!r.u && v[8 * nb - 1]) v = v | ~m;
        return v[31:0];
    endfunction

    function automatic logic [31:0] rep(input req_t r);
        logic [31:0] res;
        int nbits = 8 << r.sz;
        for (int i = 0; i < 32; i++) res[i] = r.wdata[i % nbits];
        return res;
    endfunction

    vec_t tbl[10];
    req_t q[$];
    req_t cur;
    bit   have;
    bit   erv;
    logic hr;
    logic [31:0] hd;
    logic [31:0] ea;

    initial begin
        tbl[0] = '{'1,'0,'0,2'd0,32'h1003,32'h0,'1,'0,32'h0,
                   2'd2,'1,'0,'0,32'h0,'0,32'h0};
        tbl[1] = '{'1,'0,'1,2'd0,32'h1003,32'h0,'1,'0,32'h80FF_0000,
                   2'd2,'1,'1,'0,32'hFFFF_FF80,'0,32'h0};
        tbl[2] = '{'1,'1,'0,2'd1,32'h1002,32'h0000_BEEF,'1,'0,32'h80FF_0000,
                   2'd2,'1,'1,'0,32'h0000_0080,'0,32'h0};
        tbl[3] = '{'0,'0,'0,2'd0,32'h0,32'h0,'1,'0,32'h1234_5678,
                   2'd0,'1,'1,'0,32'h0,'1,32'hBEEF_BEEF};
        tbl[4] = '{'1,'0,'0,2'd2,32'h100,32'h0,'1,'0,32'h0,
                   2'd2,'1,'0,'0,32'h0,'0,32'h0};
        tbl[5] = '{'1,'0,'0,2'd2,32'h104,32'h0,'0,'0,32'h0,
                   2'd2,'0,'0,'0,32'h0,'0,32'h0};
        tbl[6] = tbl[5];
        tbl[7] = '{'1,'0,'0,2'd2,32'h104,32'h0,'1,'0,32'hAAAA_0001,
                   2'd2,'1,'1,'0,32'hAAAA_0001,'0,32'h0};
        tbl[8] = '{'0,'0,'0,2'd0,32'h0,32'h0,'1,'0,32'h5555_0002,
                   2'd0,'1,'1,'0,32'h5555_0002,'0,32'h0};
        tbl[9] = '{'0,'0,'0,2'd0,32'h0,32'h0,'1,'0,32'h0,
                   2'd0,'1,'0,'0,32'h0,'0,32'h0};

        bif.lsu_req_valid = 1'b0; bif.lsu_req_write = 1'b0;
        bif.lsu_req_unsigned = 1'b0; bif.lsu_req_size = 2'd0;
        bif.lsu_req_addr = '0; bif.lsu_req_wdata = '0;
        bif.dbus_hready = 1'b1; bif.dbus_hresp = 1'b0; bif.dbus_hrdata = '0;
        bif64.lsu_req_valid = 1'b0; bif64.lsu_req_write = 1'b0;
        bif64.lsu_req_unsigned = 1'b0; bif64.lsu_req_size = 2'd0;
        bif64.lsu_req_addr = '0; bif64.lsu_req_wdata = '0;
        bif64.dbus_hready = 1'b1; bif64.dbus_hresp = 1'b0;
        bif64.dbus_hrdata = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_htrans", bif.dbus_htrans, 2'b00);
        chk("rst_rvalid", bif.lsu_resp_valid, 1'b0);
        chk("rst_err", bif.lsu_resp_err, 1'b0);
        chk("rst_mis", bif.lsu_misaligned, 1'b0);
        chk("rst_rdata", bif.lsu_resp_rdata, 32'h0);
        chk("rst_hwdata", bif.dbus_hwdata, 32'h0);
        chk("rst_ready_hi", bif.lsu_req_ready, 1'b1);
        bif.dbus_hready = 1'b0;
        #1;
        chk("rst_ready_lo", bif.lsu_req_ready, 1'b0);
        chk("rst_hburst", bif.dbus_hburst, 3'b000);
        chk("rst_hprot", bif.dbus_hport, 4'b0001);
        chk("rst_hlock", bif.dbus_hmastlock, 1'b0);
        rst_n = 1'b1;

        // Vector table: LB/LBU/SH, then back-to-back LW with 2 waits
        for (int i = 0; i < 10; i++) begin
            drv(tbl[i].v, tbl[i].w, tbl[i].u, tbl[i].sz, tbl[i].a,
                tbl[i].wd, tbl[i].hr, tbl[i].he, tbl[i].hd);
            check_vec(i, tbl[i]);
        end

        // ERROR on SW with a queued LW behind it
        drv(1'b1, 1'b1, 1'b0, 2'd2, 32'h200, 32'h1122_3344,
            1'b1, 1'b0, 32'h0);
        chk("err0_htrans", bif.dbus_htrans, 2'b10);
        chk("err0_ready", bif.lsu_req_ready, 1'b1);
        drv(1'b1, 1'b0, 1'b0, 2'd2, 32'h204, 32'h0, 1'b0, 1'b1, 32'h0);
        chk("err1_htrans", bif.dbus_htrans, 2'b00);
        chk("err1_ready", bif.lsu_req_ready, 1'b0);
        chk("err1_rvalid", bif.lsu_resp_valid, 1'b0);
        chk("err1_hwdata", bif.dbus_hwdata, 32'h1122_3344);
        drv(1'b1, 1'b0, 1'b0, 2'd2, 32'h204, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFF);
        chk("err2_htrans", bif.dbus_htrans, 2'b00);
        chk("err2_ready", bif.lsu_req_ready, 1'b0);
        chk("err2_rvalid", bif.lsu_resp_valid, 1'b1);
        chk("err2_err", bif.lsu_resp_err, 1'b1);
        chk("err2_rdata", bif.lsu_resp_rdata, 32'h0);
        drv(1'b1, 1'b0, 1'b0, 2'd2, 32'h204, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("err3_htrans", bif.dbus_htrans, 2'b10);
        chk("err3_haddr", bif.dbus_haddr, 32'h204);
        chk("err3_ready", bif.lsu_req_ready, 1'b1);
        chk("err3_rvalid", bif.lsu_resp_valid, 1'b0);
        drv(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 1'b0, 32'hCAFE_F00D);
        chk("err4_rvalid", bif.lsu_resp_valid, 1'b1);
        chk("err4_err", bif.lsu_resp_err, 1'b0);
        chk("err4_rdata", bif.lsu_resp_rdata, 32'hCAFE_F00D);

        // LW at 0x1002: trapped, or aligned down to 0x1000
        drv(1'b1, 1'b0, 1'b0, 2'd2, 32'h1002, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("mis0_htrans", bif.dbus_htrans, TRAP ? 2'b00 : 2'b10);
        if (!TRAP) chk("mis0_haddr", bif.dbus_haddr, 32'h1000);
        chk("mis0_ready", bif.lsu_req_ready, 1'b1);
        drv(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, !TRAP, 1'b0, 32'h0BAD_F00D);
        chk("mis1_rvalid", bif.lsu_resp_valid, 1'b1);
        chk("mis1_mis", bif.lsu_misaligned, TRAP);
        chk("mis1_err", bif.lsu_resp_err, 1'b0);
        chk("mis1_rdata", bif.lsu_resp_rdata, TRAP ? 32'h0 : 32'h0BAD_F00D);

        // Reset in the middle of a data phase: no response afterwards
        drv(1'b1, 1'b0, 1'b0, 2'd2, 32'h300, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("rmid0_ready", bif.lsu_req_ready, 1'b1);
        drv(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("rmid1_rvalid", bif.lsu_resp_valid, 1'b0);
        drv(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF);
        rst_n = 1'b1;
        #1;
        chk("rmid2_rvalid", bif.lsu_resp_valid, 1'b0);
        chk("rmid2_rdata", bif.lsu_resp_rdata, 32'h0);

        // 64-bit bus: LD at 0x8 then LWU at 0xC
        @(negedge clk);
        bif64.lsu_req_valid = 1'b1;
        bif64.lsu_req_size = 2'd3;
        bif64.lsu_req_addr = 32'h8;
        #1;
        chk("d64_ld_htrans", bif64.dbus_htrans, 2'b10);
        chk("d64_ld_hsize", bif64.dbus_hsize, 3'b011);
        @(negedge clk);
        bif64.lsu_req_size = 2'd2;
        bif64.lsu_req_unsigned = 1'b1;
        bif64.lsu_req_addr = 32'hC;
        bif64.dbus_hrdata = 64'hFFFF_FFFF_0000_0001;
        #1;
        chk("d64_ld_rvalid", bif64.lsu_resp_valid, 1'b1);
        chk("d64_ld_rdata", bif64.lsu_resp_rdata, 64'hFFFF_FFFF_0000_0001);
        chk("d64_lwu_haddr", bif64.dbus_haddr, 32'hC);
        @(negedge clk);
        bif64.lsu_req_valid = 1'b0;
        #1;
        chk("d64_lwu_rvalid", bif64.lsu_resp_valid, 1'b1);
        chk("d64_lwu_rdata", bif64.lsu_resp_rdata, 64'h0000_0000_FFFF_FFFF);

        // Random traffic against a queue-based reference
        have = 1'b0;
        cur  = '{1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0};
        for (int c = 0; c < 400; c++) begin
            if (!have && $urandom_range(0, 3) != 0) begin
                cur.w     = 1'($urandom_range(0, 1));
                cur.u     = 1'($urandom_range(0, 1));
                cur.sz    = 2'($urandom_range(0, 2));
                cur.addr  = 32'h1000 + $urandom_range(0, 63);
                cur.wdata = $urandom;
                cur.mis   = TRAP && ((cur.addr % (1 << cur.sz)) != 0);
                have      = 1'b1;
            end
            hr = ($urandom_range(0, 3) != 0);
            hd = $urandom;
            drv(have, cur.w, cur.u, cur.sz, cur.addr, cur.wdata,
                hr, 1'b0, hd);
            chk("rnd_htrans", bif.dbus_htrans,
                (have && !cur.mis) ? 2'b10 : 2'b00);
            if (have && !cur.mis) begin
                ea = cur.addr & ~((32'd1 << cur.sz) - 32'd1);
                chk("rnd_haddr", bif.dbus_haddr, ea);
                chk("rnd_hsize", bif.dbus_hsize, {1'b0, cur.sz});
                chk("rnd_hwrite", bif.dbus_hwrite, cur.w);
            end
            chk("rnd_ready", bif.lsu_req_ready, hr);
            erv = (q.size() > 0) && (q[0].mis || hr);
            chk("rnd_rvalid", bif.lsu_resp_valid, erv);
            if (erv) begin
                chk("rnd_rdata", bif.lsu_resp_rdata, exp_load(q[0], hd));
                chk("rnd_mis", bif.lsu_misaligned, q[0].mis);
                chk("rnd_err", bif.lsu_resp_err, 1'b0);
            end
            if (q.size() > 0 && q[0].w && !q[0].mis)
                chk("rnd_hwdata", bif.dbus_hwdata, rep(q[0]));
            if (erv) void'(q.pop_front());
            if (have && hr) begin
                q.push_back(cur);
                have = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/lsu_ahb.md
# lsu_ahb

Parametrised AHB-Lite load/store unit for the veriRISCV core, sitting between the MEM stage and the data bus. It accepts one load or store per cycle over a valid/ready request interface. It drives fully pipelined AHB-Lite transfers (address phase of request N overlapping data phase of N-1) and honours wait states and the two-cycle ERROR response. It returns lane-extracted, sign- or zero-extended load data on a response interface, for 32- or 64-bit data buses.

## Interface
Parameters:
- DATA_W, 32, bus/register width; 32 or 64 only.
- ADDR_W, 32, byte address width on dbus_haddr.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous, active-low reset
- lsu_req_valid  in  1  request present; must stay asserted with stable fields until accepted
- lsu_req_ready  out  1  request accepted this cycle when valid&ready
- lsu_req_write  in  1  1=store, 0=load
- lsu_req_size  in  2  00 byte, 01 half, 10 word, 11 dword (legal only when DATA_W=64)
- lsu_req_unsigned  in  1  zero-extend load (LBU/LHU/LWU)
- lsu_req_addr  in  ADDR_W  byte address
- lsu_req_wdata  in  DATA_W  store data, LSB-justified
- lsu_resp_valid  out  1  response for oldest accepted request
- lsu_resp_rdata  out  DATA_W  extended load data; 0 for stores/errors
- lsu_resp_err  out  1  bus ERROR response
- lsu_misaligned  out  1  misaligned-access exception (qualified by lsu_resp_valid)
- dbus_hwrite, dbus_hsize[2:0], dbus_hburst[2:0], dbus_hport[3:0], dbus_htrans[1:0], dbus_hmastlock, dbus_haddr[ADDR_W], dbus_hwdata[DATA_W]  out  AHB-Lite master
- dbus_hready, dbus_hresp, dbus_hrdata[DATA_W]  in  AHB-Lite slave response

## Operation
- Address phase is combinational from the request: htrans=NONSEQ(10) when lsu_req_valid, not cancelled, and the access is aligned; otherwise IDLE(00). hsize={0,lsu_req_size}, hburst=000, hport=0001, hmastlock=0.
- lsu_req_ready = dbus_hready & ~cancel. Acceptance loads the data-phase register: dp_valid, write, size, unsigned, addr low bits, misaligned flag. It also loads dbus_hwdata with store data replicated across all lanes (byte x DATA_W/8, half x DATA_W/16, word x DATA_W/32).
- Data phase ends at the first cycle with dp_valid & dbus_hready. That cycle: lsu_resp_valid=1, and for loads lsu_resp_rdata is the selected lane of dbus_hrdata, extended per size/unsigned.
- Error: cycle 1 (hresp=1, hready=0) sets cancel, which forces htrans=IDLE and lsu_req_ready=0. Cycle 2 (hresp=1, hready=1) gives resp_valid=1, resp_err=1, rdata=0, and clears cancel and dp_valid. No request is accepted in cycle 2.
- Misaligned requests (address not a multiple of 2^size) are accepted without a bus transfer. The response comes the next cycle with lsu_misaligned=1, independent of hready.

## Timing
- Reset (rst_n=0 at clk edge): dp_valid=0, cancel=0, dbus_hwdata=0. Outputs settle to: htrans=IDLE, resp_valid=0, resp_err=0, misaligned=0, rdata=0, req_ready=dbus_hready.
- Reset mid-transfer abandons the data phase with no response.
- Zero-wait-state latency: response 1 cycle after acceptance; throughput 1 per cycle.
- Each wait state adds one cycle. The address is held by the requester and stays stable via the valid rule.
- Same-cycle response N and acceptance N+1 is normal. Response order always equals request order.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: misaligned detection and the lsu_misaligned response as above.
- LSU_MISALIGN_TRAP_EN undefined: lsu_misaligned tied 0. dbus_haddr low bits are cleared to size alignment, and the access proceeds as an aligned transfer.

## Structure
- Shared header lsu.vh: size encodings (LSU_SIZE_B/H/W/D), HTRANS_IDLE/NONSEQ, HSIZE values.
- Sub-module lsu_rdata_align holds the combinational lane select and sign/zero extension, parametrised by DATA_W and reused by future cache paths.
- All remaining logic (data-phase register, cancel FSM IDLE/DATA/ERR1, wdata replication) lives in lsu_ahb.

## Test plan
- LB at 0x1003 with hrdata=0x80FF_0000, zero waits: resp next cycle, rdata=0xFFFF_FF80; LBU gives 0x0000_0080.
- SH 0xBEEF at 0x1002: hsize=001, haddr=0x1002; hwdata=0xBEEF_BEEF in the data phase.
- Back-to-back LW 0x100 then LW 0x104 with 2 wait states on the first: second address held 3 cycles, responses in order, no duplicate NONSEQ.
- ERROR on SW: cycle 1 shows htrans=IDLE and req_ready=0; cycle 2 shows resp_err=1 and rdata=0; the next queued request is issued in cycle 3.
- LW at 0x1002 with LSU_MISALIGN_TRAP_EN: htrans stays IDLE, lsu_misaligned=1 next cycle. Without the macro: haddr=0x1000, normal response.
- DATA_W=64, LD at 0x8 and LWU at 0xC with hrdata=0xFFFF_FFFF_0000_0001: rdata=0xFFFF_FFFF_0000_0001 and 0x0000_0000_FFFF_FFFF.
